// File: rtl/req_ack_multi_pkg.sv
// Shared types and constants for the multi-channel req/ack stimulus generator.
package req_ack_multi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        ACK,
        GAP
    } state_e;

    localparam logic [1:0] MODE_PULSE = 2'd0;
    localparam logic [1:0] MODE_LEVEL = 2'd1;
    localparam logic [1:0] MODE_NOACK = 2'd2;

endpackage

// File: rtl/req_ack_chan.sv
// One req/ack channel: Moore FSM with per-transaction latched mode, ack delay and gap.
module req_ack_chan
    import req_ack_multi_pkg::*;
#(
    parameter int DLY_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             go,
    input  logic [1:0]       mode,
    input  logic [DLY_W-1:0] ack_dly,
    input  logic [DLY_W-1:0] gap,
    output logic             req,
    output logic             ack,
    output logic             done,
    output logic             idle
);

    state_e           state_q, state_d;
    logic [DLY_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q;
    logic [DLY_W-1:0] dly_q, gap_q;
    logic             load;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d = REQ;
                    load    = 1'b1;
                end
            end
            REQ: begin
                if (dly_q != '0) begin
                    state_d = WAIT;
                    cnt_d   = dly_q - DLY_W'(1);
                end else begin
                    state_d = ACK;
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = ACK;
                else             cnt_d   = cnt_q - DLY_W'(1);
            end
            ACK: begin
                if (gap_q != '0) begin
                    state_d = GAP;
                    cnt_d   = gap_q - DLY_W'(1);
                end else if (go) begin
                    state_d = REQ;
                    load    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DLY_W'(1);
                end else if (go) begin
                    state_d = REQ;
                    load    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_PULSE;
            dly_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                mode_q <= mode;
                dly_q  <= ack_dly;
                gap_q  <= gap;
            end
        end
    end

    // Outputs depend only on registered state and latched mode; mode 3 falls through as PULSE.
    always_comb begin
        req  = (state_q == REQ) ||
               ((mode_q == MODE_LEVEL) && ((state_q == WAIT) || (state_q == ACK)));
        ack  = (state_q == ACK) && (mode_q != MODE_NOACK);
        done = (state_q == ACK);
        idle = (state_q == IDLE);
    end

endmodule

// File: rtl/req_ack_multi_gen.sv
// Multi-channel req/ack stimulus generator: channel array, busy flag and transaction counter.
module req_ack_multi_gen
    import req_ack_multi_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DLY_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [1:0]        mode,
    input  logic [DLY_W-1:0]  ack_dly,
    input  logic [DLY_W-1:0]  gap,
    output logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] ack,
    output logic [NUM_CH-1:0] done,
    output logic              busy,
    output logic [CNT_W-1:0]  txn_cnt
);

    logic [NUM_CH-1:0] idle;
    logic [CNT_W-1:0]  done_sum;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        req_ack_chan #(
            .DLY_W (DLY_W)
        ) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .go      (enable && ch_en[i]),
            .mode    (mode),
            .ack_dly (ack_dly),
            .gap     (gap),
            .req     (req[i]),
            .ack     (ack[i]),
            .done    (done[i]),
            .idle    (idle[i])
        );
    end

    assign busy = ~&idle;

    // Channels finishing in the same cycle are all counted in one update.
    always_comb begin
        done_sum = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            done_sum = done_sum + CNT_W'(done[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) txn_cnt <= '0;
        else          txn_cnt <= txn_cnt + done_sum;
    end

endmodule

// File: tb/tb_req_ack_multi_gen.sv
// Self-checking bench for req_ack_multi_gen: vector table, directed corner sequences, random vs model.
module tb_req_ack_multi_gen;

    localparam int NCH = 2;

    logic           clk;
    logic           reset_n;
    logic           enable;
    logic [NCH-1:0] ch_en;
    logic [1:0]     mode;
    logic [3:0]     ack_dly;
    logic [3:0]     gap;
    logic [NCH-1:0] req;
    logic [NCH-1:0] ack;
    logic [NCH-1:0] done;
    logic           busy;
    logic [15:0]    txn_cnt;

    int checks = 0;
    int errors = 0;

    req_ack_multi_gen #(
        .NUM_CH (NCH),
        .DLY_W  (4),
        .CNT_W  (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .ch_en   (ch_en),
        .mode    (mode),
        .ack_dly (ack_dly),
        .gap     (gap),
        .req     (req),
        .ack     (ack),
        .done    (done),
        .busy    (busy),
        .txn_cnt (txn_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: each active channel tracks its position t (1-based) inside a
    // transaction of length 2+D+G; t==0 means parked.
    int          m_t  [NCH];
    int          m_md [NCH];
    int          m_d  [NCH];
    int          m_g  [NCH];
    logic [15:0] m_cnt;

    function automatic logic [NCH-1:0] m_req();
        logic [NCH-1:0] r = '0;
        for (int i = 0; i < NCH; i++)
            r[i] = (m_t[i] == 1) || (m_md[i] == 1 && m_t[i] >= 1 && m_t[i] <= m_d[i] + 2);
        return r;
    endfunction

    function automatic logic [NCH-1:0] m_done();
        logic [NCH-1:0] r = '0;
        for (int i = 0; i < NCH; i++)
            r[i] = (m_t[i] != 0) && (m_t[i] == m_d[i] + 2);
        return r;
    endfunction

    function automatic logic [NCH-1:0] m_ack();
        logic [NCH-1:0] r = m_done();
        for (int i = 0; i < NCH; i++)
            if (m_md[i] == 2) r[i] = 1'b0;
        return r;
    endfunction

    function automatic logic m_busy();
        logic b = 1'b0;
        for (int i = 0; i < NCH; i++)
            if (m_t[i] != 0) b = 1'b1;
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_t[i] = 0; m_md[i] = 0; m_d[i] = 0; m_g[i] = 0;
        end
        m_cnt = '0;
    endtask

    task automatic model_edge();
        logic [NCH-1:0] dn = m_done();
        for (int i = 0; i < NCH; i++) begin
            logic go = enable && ch_en[i];
            m_cnt = m_cnt + 16'(dn[i]);
            if (m_t[i] == 0 || m_t[i] == m_d[i] + 2 + m_g[i]) begin
                if (go) begin
                    m_t[i] = 1; m_md[i] = int'(mode); m_d[i] = int'(ack_dly); m_g[i] = int'(gap);
                end else begin
                    m_t[i] = 0;
                end
            end else begin
                m_t[i]++;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic           en;
        logic [NCH-1:0] ch;
        logic [1:0]     md;
        logic [3:0]     d;
        logic [3:0]     g;
        logic [NCH-1:0] ereq;
        logic [NCH-1:0] eack;
        logic [NCH-1:0] edone;
        logic           ebusy;
        logic [15:0]    ecnt;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [NCH-1:0] e;

        // Default pattern on both channels, then enable dropped while both sit in GAP.
        tbl[0] = '{1'b1, 2'b11, 2'd0, 4'd0, 4'd1, 2'b11, 2'b00, 2'b00, 1'b1, 16'd0};
        tbl[1] = '{1'b1, 2'b11, 2'd0, 4'd0, 4'd1, 2'b00, 2'b11, 2'b11, 1'b1, 16'd0};
        tbl[2] = '{1'b1, 2'b11, 2'd0, 4'd0, 4'd1, 2'b00, 2'b00, 2'b00, 1'b1, 16'd2};
        tbl[3] = '{1'b1, 2'b11, 2'd0, 4'd0, 4'd1, 2'b11, 2'b00, 2'b00, 1'b1, 16'd2};
        tbl[4] = '{1'b1, 2'b11, 2'd0, 4'd0, 4'd1, 2'b00, 2'b11, 2'b11, 1'b1, 16'd2};
        tbl[5] = '{1'b1, 2'b11, 2'd0, 4'd0, 4'd1, 2'b00, 2'b00, 2'b00, 1'b1, 16'd4};
        tbl[6] = '{1'b1, 2'b11, 2'd0, 4'd0, 4'd1, 2'b11, 2'b00, 2'b00, 1'b1, 16'd4};
        tbl[7] = '{1'b1, 2'b11, 2'd0, 4'd0, 4'd1, 2'b00, 2'b11, 2'b11, 1'b1, 16'd4};
        tbl[8] = '{1'b1, 2'b11, 2'd0, 4'd0, 4'd1, 2'b00, 2'b00, 2'b00, 1'b1, 16'd6};
        tbl[9] = '{1'b0, 2'b11, 2'd0, 4'd0, 4'd1, 2'b00, 2'b00, 2'b00, 1'b0, 16'd6};

        reset_n = 1'b0;
        enable  = 1'b0;
        ch_en   = '0;
        mode    = 2'd0;
        ack_dly = 4'd0;
        gap     = 4'd1;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_req",  32'(req),     32'd0);
        check("rst_ack",  32'(ack),     32'd0);
        check("rst_done", 32'(done),    32'd0);
        check("rst_busy", 32'(busy),    32'd0);
        check("rst_cnt",  32'(txn_cnt), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            enable = tbl[i].en; ch_en = tbl[i].ch; mode = tbl[i].md;
            ack_dly = tbl[i].d; gap = tbl[i].g;
            step();
            check($sformatf("tbl%0d_req", i),  32'(req),     32'(tbl[i].ereq));
            check($sformatf("tbl%0d_ack", i),  32'(ack),     32'(tbl[i].eack));
            check($sformatf("tbl%0d_done", i), 32'(done),    32'(tbl[i].edone));
            check($sformatf("tbl%0d_busy", i), 32'(busy),    32'(tbl[i].ebusy));
            check($sformatf("tbl%0d_cnt", i),  32'(txn_cnt), 32'(tbl[i].ecnt));
        end

        // Asynchronous reset while both channels hold req in LEVEL mode during WAIT.
        enable = 1'b1; ch_en = 2'b11; mode = 2'd1; ack_dly = 4'd5; gap = 4'd1;
        repeat (3) step();
        check("wait_req", 32'(req),     32'h3);
        check("wait_cnt", 32'(txn_cnt), 32'd6);
        reset_n = 1'b0;
        #1;
        check("arst_req",  32'(req),     32'd0);
        check("arst_ack",  32'(ack),     32'd0);
        check("arst_done", 32'(done),    32'd0);
        check("arst_busy", 32'(busy),    32'd0);
        check("arst_cnt",  32'(txn_cnt), 32'd0);
        enable = 1'b0;
        #1;
        reset_n = 1'b1;

        // LEVEL, D=3, G=0 on channel 0: req held 5 cycles, ack in the 5th, period 5.
        @(negedge clk);
        enable = 1'b1; ch_en = 2'b01; mode = 2'd1; ack_dly = 4'd3; gap = 4'd0;
        for (int c = 1; c <= 10; c++) begin
            step();
            check($sformatf("lvl%0d_req", c), 32'(req), 32'h1);
            e = {1'b0, logic'(c % 5 == 0)};
            check($sformatf("lvl%0d_ack", c), 32'(ack), 32'(e));
        end
        enable = 1'b0;
        do_reset();

        // NOACK, D=2, G=1: ack never rises, done every 5 cycles, counter still counts.
        @(negedge clk);
        enable = 1'b1; ch_en = 2'b01; mode = 2'd2; ack_dly = 4'd2; gap = 4'd1;
        for (int c = 1; c <= 10; c++) begin
            step();
            check($sformatf("noack%0d_ack", c), 32'(ack), 32'd0);
            e = {1'b0, logic'(c % 5 == 4)};
            check($sformatf("noack%0d_done", c), 32'(done), 32'(e));
        end
        check("noack_cnt", 32'(txn_cnt), 32'd2);
        enable = 1'b0;
        do_reset();

        // ack_dly changed 1 -> 4 during WAIT: current ack at old delay, next uses 4.
        @(negedge clk);
        enable = 1'b1; ch_en = 2'b01; mode = 2'd0; ack_dly = 4'd1; gap = 4'd0;
        for (int c = 1; c <= 9; c++) begin
            if (c == 3) ack_dly = 4'd4;
            step();
            e = {1'b0, logic'(c == 3 || c == 9)};
            check($sformatf("dchg%0d_ack", c), 32'(ack), 32'(e));
        end
        enable = 1'b0;
        do_reset();
        model_reset();

        // Randomised run against the reference model, including maximum delays and resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                enable  = ($urandom_range(0, 9) != 0);
                ch_en   = NCH'($urandom());
                mode    = 2'($urandom_range(0, 3));
                ack_dly = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
                gap     = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 499) == 0) begin
                reset_n = 1'b0;
                #1;
                model_reset();
                check("rnd_rst_cnt", 32'(txn_cnt), 32'(m_cnt));
                #1;
                reset_n = 1'b1;
            end
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check("rnd_req",  32'(req),     32'(m_req()));
            check("rnd_ack",  32'(ack),     32'(m_ack()));
            check("rnd_done", 32'(done),    32'(m_done()));
            check("rnd_busy", 32'(busy),    32'(m_busy()));
            check("rnd_cnt",  32'(txn_cnt), 32'(m_cnt));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
